// File: rtl/sop_block_accumulator.sv
// -----------------------------------------------------------------------------
// sop_block_accumulator
//
// Purpose:
//   Sits downstream of the sum-of-products stage. It accepts one unsigned
//   SUM_IN sample per input transfer and adds exactly N = 2**DEPTH_LOG2
//   samples into a block total. The total is presented on a registered
//   valid/ready output port. The producer is back-pressured only when a
//   finished block cannot be handed to the output register.
//
// Configuration macro:
//   SOP_ACC_AVG_EN - when defined, ACC_OUT carries the block mean
//                    (total >> DEPTH_LOG2, truncating, zero-extended).
//                    When undefined, ACC_OUT carries the full block total.
//
// Ports:
//   clk         in   1                      rising-edge clock
//   rst         in   1                      synchronous active-high reset
//   SUM_IN      in   WIDTH+2                unsigned input sample
//   IN_VALID    in   1                      SUM_IN is valid this cycle
//   IN_READY    out  1                      block accepts a sample this cycle
//   ACC_OUT     out  WIDTH+2+DEPTH_LOG2     registered block result
//   OUT_VALID   out  1                      ACC_OUT holds an unconsumed result
//   OUT_READY   in   1                      consumer takes ACC_OUT this cycle
//   SAMPLE_CNT  out  DEPTH_LOG2             samples accepted in current block
//   o_dbg_state out  1                      FSM state (0 = ACCUM, 1 = STALL)
//
// Handshake semantics (both ports):
//   A transfer happens on a rising edge where valid && ready are both 1.
//   Valid never waits on ready. IN_READY is decoded from the state register
//   only, so it has no combinational path from OUT_READY.
// -----------------------------------------------------------------------------
module sop_block_accumulator #(
  parameter int WIDTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH+1:0]               SUM_IN,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  output logic [WIDTH+2+DEPTH_LOG2-1:0]  ACC_OUT,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [DEPTH_LOG2-1:0]          SAMPLE_CNT,
  output logic                           o_dbg_state
);

  localparam int AW = WIDTH + 2 + DEPTH_LOG2;
  localparam int N  = 1 << DEPTH_LOG2;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [AW-1:0]         r_acc;
  logic [AW-1:0]         w_acc_nxt;
  logic [DEPTH_LOG2-1:0] r_cnt;
  logic [DEPTH_LOG2-1:0] w_cnt_nxt;
  logic [AW-1:0]         r_out;
  logic [AW-1:0]         w_out_nxt;
  logic                  r_out_valid;
  logic                  w_out_valid_nxt;

  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_last;
  logic [AW-1:0]         w_total;

  // Value written into ACC_OUT; acc itself always keeps the full total.
  function automatic logic [AW-1:0] f_shape(input logic [AW-1:0] t);
`ifdef SOP_ACC_AVG_EN
    return t >> DEPTH_LOG2;
`else
    return t;
`endif
  endfunction

  assign w_in_fire  = IN_VALID && (r_state == ST_ACCUM);
  assign w_out_fire = r_out_valid && OUT_READY;
  assign w_last     = (r_cnt == DEPTH_LOG2'(N - 1));
  // Zero-extended add; the accumulator is wide enough that it cannot wrap.
  assign w_total    = r_acc + AW'(SUM_IN);

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_out_nxt       = r_out;
    w_out_valid_nxt = r_out_valid;

    case (r_state)
      ST_ACCUM: begin
        // Consumer drained the register; a completing block below may refill it.
        if (w_out_fire) begin
          w_out_valid_nxt = 1'b0;
        end
        if (w_in_fire) begin
          if (!w_last) begin
            w_acc_nxt = w_total;
            w_cnt_nxt = r_cnt + DEPTH_LOG2'(1);
          end else if (!r_out_valid || w_out_fire) begin
            // Output register is free this edge: hand off with no bubble.
            w_out_nxt       = f_shape(w_total);
            w_out_valid_nxt = 1'b1;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
          end else begin
            // Hold the finished total in acc until the consumer takes ACC_OUT.
            w_acc_nxt   = w_total;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (w_out_fire) begin
          w_out_nxt       = f_shape(r_acc);
          w_out_valid_nxt = 1'b1;
          w_acc_nxt       = '0;
          w_state_nxt     = ST_ACCUM;
        end
      end
      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign IN_READY    = (r_state == ST_ACCUM);
  assign ACC_OUT     = r_out;
  assign OUT_VALID   = r_out_valid;
  assign SAMPLE_CNT  = r_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sop_block_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sop_block_accumulator
//
// Bench for sop_block_accumulator. The reference treats the design as a
// two-entry queue of finished block results: the head is what ACC_OUT shows,
// a full queue means the producer is held off. Partial blocks are a list of
// accepted samples whose sum becomes a result once N of them have arrived.
// -----------------------------------------------------------------------------
module tb_sop_block_accumulator;

  localparam int WIDTH      = 4;
  localparam int DEPTH_LOG2 = 2;
  localparam int SW         = WIDTH + 2;
  localparam int AW         = WIDTH + 2 + DEPTH_LOG2;
  localparam int N          = 1 << DEPTH_LOG2;

  // ---------------------------------------------------------------- clock/reset
  logic                  clk;
  logic                  rst;
  logic [SW-1:0]         SUM_IN;
  logic                  IN_VALID;
  logic                  IN_READY;
  logic [AW-1:0]         ACC_OUT;
  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic [DEPTH_LOG2-1:0] SAMPLE_CNT;
  logic                  o_dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sop_block_accumulator #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .SUM_IN      (SUM_IN),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .ACC_OUT     (ACC_OUT),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .SAMPLE_CNT  (SAMPLE_CNT),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;
  logic [AW-1:0] exp_q[$];  // finished results not yet consumed
  int          blk_q[$];    // samples accepted in the current block

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int lit(input int full, input int avg);
`ifdef SOP_ACC_AVG_EN
    return avg;
`else
    return full;
`endif
  endfunction

  // Reference update on each rising edge, from the inputs held during the cycle.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      blk_q.delete();
    end else begin
      automatic bit in_fire  = IN_VALID && (exp_q.size() < 2);
      automatic bit out_fire = OUT_READY && (exp_q.size() > 0);
      if (out_fire) void'(exp_q.pop_front());
      if (in_fire) begin
        blk_q.push_back(int'(SUM_IN));
        if (blk_q.size() == N) begin
          automatic int total = 0;
          foreach (blk_q[i]) total += blk_q[i];
`ifdef SOP_ACC_AVG_EN
          total = total / N;
`endif
          exp_q.push_back(AW'(total));
          blk_q.delete();
        end
      end
    end
  end

  // Per-cycle compare away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(OUT_VALID), 32'(exp_q.size() > 0));
      chk("in_ready", 32'(IN_READY), 32'(exp_q.size() < 2));
      chk("sample_cnt", 32'(SAMPLE_CNT), 32'(blk_q.size()));
      chk("dbg_state", 32'(o_dbg_state), 32'(exp_q.size() == 2));
      if (exp_q.size() > 0) chk("acc_out", 32'(ACC_OUT), 32'(exp_q[0]));
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic step(input logic v, input int d, input logic r);
    IN_VALID  = v;
    SUM_IN    = SW'(d);
    OUT_READY = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic chk_idle_after_reset(input string tag);
    chk({tag, "_cnt"}, 32'(SAMPLE_CNT), 0);
    chk({tag, "_ovalid"}, 32'(OUT_VALID), 0);
    chk({tag, "_iready"}, 32'(IN_READY), 1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1; IN_VALID = 1'b0; SUM_IN = '0; OUT_READY = 1'b0;
    do_reset();
    chk_en = 1'b1;
    chk_idle_after_reset("reset");
    chk("reset_acc_out", 32'(ACC_OUT), 0);

    // 10,20,30,40 with consumer ready
    step(1'b1, 10, 1'b1); chk("t1_cnt1", 32'(SAMPLE_CNT), 1);
    step(1'b1, 20, 1'b1); chk("t1_cnt2", 32'(SAMPLE_CNT), 2);
    step(1'b1, 30, 1'b1); chk("t1_cnt3", 32'(SAMPLE_CNT), 3);
    step(1'b1, 40, 1'b1);
    chk("t1_cnt0", 32'(SAMPLE_CNT), 0);
    chk("t1_valid", 32'(OUT_VALID), 1);
    chk("t1_acc", 32'(ACC_OUT), lit(100, 25));
    step(1'b0, 0, 1'b1);
    chk("t1_drained", 32'(OUT_VALID), 0);

    // Maximum samples: no wrap
    for (int i = 0; i < 4; i++) step(1'b1, 63, 1'b1);
    chk("t2_acc", 32'(ACC_OUT), lit(252, 63));
    step(1'b0, 0, 1'b1);

    // Gaps with junk on SUM_IN
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, i, 1'b1);
      if (i < 4) for (int g = 0; g < 3; g++) step(1'b0, 55, 1'b1);
    end
    chk("t3_acc", 32'(ACC_OUT), lit(10, 2));
    step(1'b0, 0, 1'b1);

    // Back-pressure across two blocks
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0);
    chk("t4_acc_first", 32'(ACC_OUT), lit(4, 1));
    for (int i = 0; i < 4; i++) step(1'b1, 2, 1'b0);
    chk("t4_stall_iready", 32'(IN_READY), 0);
    chk("t4_held_acc", 32'(ACC_OUT), lit(4, 1));
    step(1'b0, 0, 1'b1);
    chk("t4_acc_second", 32'(ACC_OUT), lit(8, 2));
    chk("t4_valid_kept", 32'(OUT_VALID), 1);
    chk("t4_iready_back", 32'(IN_READY), 1);
    step(1'b0, 0, 1'b1);

    // Continuous stream, back-to-back completions
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5, 1'b1);
      chk("t5_iready_a", 32'(IN_READY), 1);
    end
    chk("t5_acc_20", 32'(ACC_OUT), lit(20, 5));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 6, 1'b1);
      chk("t5_iready_b", 32'(IN_READY), 1);
    end
    chk("t5_acc_24", 32'(ACC_OUT), lit(24, 6));
    chk("t5_valid", 32'(OUT_VALID), 1);
    step(1'b0, 0, 1'b1);

    // Reset mid-block
    step(1'b1, 7, 1'b1);
    step(1'b1, 7, 1'b1);
    do_reset();
    chk_idle_after_reset("t6_mid");
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b1);
    chk("t6_acc", 32'(ACC_OUT), lit(4, 1));
    step(1'b0, 0, 1'b1);

    // Reset while stalled
    for (int i = 0; i < 8; i++) step(1'b1, 1, 1'b0);
    chk("t7_stalled", 32'(IN_READY), 0);
    do_reset();
    chk_idle_after_reset("t7_stall");
    for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b1);
    chk("t7_acc", 32'(ACC_OUT), lit(4, 1));
    step(1'b0, 0, 1'b1);

    // Randomised traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      step(logic'($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)),
           logic'($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;
    step(1'b0, 0, 1'b1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
